packet_sf_fifo: RTL and testbench



---
 rtl/pkt_stream_pkg.sv | 9 +
 rtl/sync_fifo_core.sv | 41 ++++
 rtl/packet_sf_fifo.sv | 60 ++++++
 tb/tb_packet_sf_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_stream_pkg.sv
// pkt_stream_pkg: shared definitions for the packet stream blocks
package pkt_stream_pkg;
    localparam int DEFAULT_D_WIDTH = 6;

    // tlast rides in the MSB of every beat
    function automatic logic tlast_of(input logic [63:0] data, input int width);
        return data[6'(width - 1)];
    endfunction
endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: register-array FIFO with wrap-bit pointers, full/empty and level
module sync_fifo_core #(
    parameter int D_WIDTH = 6,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        level
);
    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // storage is not reset; stale entries are never visible past the pointers
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // pointers advance with natural wrap; the MSB distinguishes full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level   = wr_ptr - rd_ptr;
endmodule

// File: rtl/packet_sf_fifo.sv
// packet_sf_fifo: store-and-forward packet FIFO with forced cut-through for oversize packets
module packet_sf_fifo
    import pkt_stream_pkg::*;
#(
    parameter int D_WIDTH = DEFAULT_D_WIDTH,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready,
    output logic [AW:0]        level,
    output logic [AW:0]        pkt_count
);
    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;
    logic wr_last;
    logic rd_last;
    logic cut_through;

    sync_fifo_core #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (up_data),
        .rd_en   (rd_en),
        .rd_data (down_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign up_ready   = ~full & ~rst;
    assign wr_en      = up_valid & up_ready;
    assign rd_en      = down_valid & down_ready;
    assign wr_last    = tlast_of(64'(up_data), D_WIDTH);
    assign rd_last    = tlast_of(64'(down_data), D_WIDTH);
    assign down_valid = ~empty & ((pkt_count != '0) | cut_through);

    // count of complete packets held; simultaneous tlast in and out cancel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pkt_count <= '0;
        else if (wr_en && wr_last && !(rd_en && rd_last)) pkt_count <= pkt_count + 1'b1;
        else if (rd_en && rd_last && !(wr_en && wr_last)) pkt_count <= pkt_count - 1'b1;
    end

    // a full FIFO with no complete packet can only drain by releasing the head early
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cut_through <= 1'b0;
        else if (rd_en && rd_last) cut_through <= 1'b0;
        else if (full && pkt_count == '0) cut_through <= 1'b1;
    end
endmodule

// File: tb/tb_packet_sf_fifo.sv
// tb_packet_sf_fifo: directed vector table plus hand sequences for packet_sf_fifo
module tb_packet_sf_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] up_data = '0;
    logic       up_valid = 1'b0;
    logic       up_ready;
    logic [5:0] down_data;
    logic       down_valid;
    logic       down_ready = 1'b0;
    logic [3:0] level;
    logic [3:0] pkt_count;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic       uv;
        logic [5:0] d;
        logic       dr;
        logic       ur;
        logic       dv;
        logic [5:0] dd;
        logic [3:0] lvl;
        logic [3:0] pc;
    } vec_t;

    vec_t tv[$];

    packet_sf_fifo #(.D_WIDTH(6), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .level      (level),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic uv, input logic [5:0] d, input logic dr, input logic ur,
                       input logic dv, input logic [5:0] dd, input logic [3:0] lvl, input logic [3:0] pc);
        vec_t v;
        v = '{uv, d, dr, ur, dv, dd, lvl, pc};
        tv.push_back(v);
    endtask

    // beats of the 10-beat oversize packet; only the last one carries tlast
    function automatic logic [5:0] beat(input int i);
        return (i < 9) ? 6'(i + 1) : (i == 9) ? 6'h2A : 6'h00;
    endfunction

    task automatic check_all(input string tag, input logic ur, input logic dv, input logic [5:0] dd,
                             input logic [3:0] lvl, input logic [3:0] pc);
        chk({tag, " up_ready"}, 8'(up_ready), 8'(ur));
        chk({tag, " down_valid"}, 8'(down_valid), 8'(dv));
        chk({tag, " level"}, 8'(level), 8'(lvl));
        chk({tag, " pkt_count"}, 8'(pkt_count), 8'(pc));
        if (dv) chk({tag, " down_data"}, 8'(down_data), 8'(dd));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n_in;
        int n_out;
        // single 3-beat packet, visible only after its tlast beat lands
        add(1, 6'h01, 1, 1, 0, 6'h00, 0, 0);
        add(1, 6'h02, 1, 1, 0, 6'h00, 1, 0);
        add(1, 6'h23, 1, 1, 0, 6'h00, 2, 0);
        add(0, 6'h00, 1, 1, 1, 6'h01, 3, 1);
        add(0, 6'h00, 1, 1, 1, 6'h02, 2, 1);
        add(0, 6'h00, 1, 1, 1, 6'h23, 1, 1);
        add(0, 6'h00, 0, 1, 0, 6'h00, 0, 0);
        // two 4-beat packets fill the FIFO with the sink stalled
        add(1, 6'h01, 0, 1, 0, 6'h00, 0, 0);
        add(1, 6'h02, 0, 1, 0, 6'h00, 1, 0);
        add(1, 6'h03, 0, 1, 0, 6'h00, 2, 0);
        add(1, 6'h24, 0, 1, 0, 6'h00, 3, 0);
        add(1, 6'h05, 0, 1, 1, 6'h01, 4, 1);
        add(1, 6'h06, 0, 1, 1, 6'h01, 5, 1);
        add(1, 6'h07, 0, 1, 1, 6'h01, 6, 1);
        add(1, 6'h28, 0, 1, 1, 6'h01, 7, 1);
        add(1, 6'h3F, 0, 0, 1, 6'h01, 8, 2);
        add(0, 6'h00, 0, 0, 1, 6'h01, 8, 2);
        add(0, 6'h00, 1, 0, 1, 6'h01, 8, 2);
        add(0, 6'h00, 1, 1, 1, 6'h02, 7, 2);
        add(0, 6'h00, 1, 1, 1, 6'h03, 6, 2);
        add(0, 6'h00, 1, 1, 1, 6'h24, 5, 2);
        add(0, 6'h00, 1, 1, 1, 6'h05, 4, 1);
        add(0, 6'h00, 1, 1, 1, 6'h06, 3, 1);
        add(0, 6'h00, 1, 1, 1, 6'h07, 2, 1);
        add(0, 6'h00, 1, 1, 1, 6'h28, 1, 1);
        add(0, 6'h00, 1, 1, 0, 6'h00, 0, 0);
        // simultaneous tlast write and tlast read
        add(1, 6'h21, 0, 1, 0, 6'h00, 0, 0);
        add(1, 6'h33, 1, 1, 1, 6'h21, 1, 1);
        add(0, 6'h00, 0, 1, 1, 6'h33, 1, 1);
        // sink backpressure toggling 1,0,0,1
        add(1, 6'h05, 0, 1, 1, 6'h33, 1, 1);
        add(1, 6'h26, 1, 1, 1, 6'h33, 2, 1);
        add(0, 6'h00, 0, 1, 1, 6'h05, 2, 1);
        add(0, 6'h00, 0, 1, 1, 6'h05, 2, 1);
        add(0, 6'h00, 1, 1, 1, 6'h05, 2, 1);
        add(0, 6'h00, 1, 1, 1, 6'h26, 1, 1);
        add(0, 6'h00, 0, 1, 0, 6'h00, 0, 0);

        #2;
        check_all("reset", 0, 0, 6'h00, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset release up_ready", 8'(up_ready), 8'h01);
        @(posedge clk);
        #1;

        foreach (tv[i]) begin
            up_valid   = tv[i].uv;
            up_data    = tv[i].d;
            down_ready = tv[i].dr;
            @(negedge clk);
            check_all($sformatf("v%0d", i), tv[i].ur, tv[i].dv, tv[i].dd, tv[i].lvl, tv[i].pc);
            @(posedge clk);
            #1;
        end

        // oversize 10-beat packet forces cut-through
        down_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            up_valid = 1'b1;
            up_data  = beat(i);
            @(negedge clk);
            chk($sformatf("t3 fill%0d up_ready", i), 8'(up_ready), 8'h01);
            chk($sformatf("t3 fill%0d down_valid", i), 8'(down_valid), 8'h00);
            @(posedge clk);
            #1;
        end
        up_data = beat(8);
        @(negedge clk);
        check_all("t3 full", 0, 0, 6'h00, 8, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_all("t3 cut", 0, 1, 6'h01, 8, 0);
        n_in  = 8;
        n_out = 0;
        for (int c = 0; c < 60 && n_out < 10; c++) begin
            if (down_valid && down_ready) begin
                chk($sformatf("t3 beat%0d", n_out), 8'(down_data), 8'(beat(n_out)));
                n_out++;
            end
            if (up_valid && up_ready) n_in++;
            @(posedge clk);
            #1;
            up_valid = n_in < 10;
            up_data  = beat(n_in);
            @(negedge clk);
        end
        chk("t3 beats out", 8'(n_out), 8'd10);
        check_all("t3 drained", 1, 0, 6'h00, 0, 0);
        // cut-through must be cleared: a partial packet stays hidden
        up_valid = 1'b1;
        up_data  = 6'h01;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        @(negedge clk);
        check_all("t3 partial", 1, 0, 6'h00, 1, 0);
        up_valid = 1'b1;
        up_data  = 6'h20;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        @(negedge clk);
        check_all("t3 tail0", 1, 1, 6'h01, 2, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_all("t3 tail1", 1, 1, 6'h20, 1, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_all("t3 tail2", 1, 0, 6'h00, 0, 0);

        // reset asserted mid-packet between clock edges
        down_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_valid = 1'b1;
            up_data  = (i == 0) ? 6'h21 : 6'(i);
            @(posedge clk);
            #1;
        end
        up_valid = 1'b0;
        @(negedge clk);
        check_all("t5 pre", 1, 1, 6'h21, 4, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all("t5 in reset", 0, 0, 6'h00, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("t5 release", 1, 0, 6'h00, 0, 0);
        @(posedge clk);
        #1;
        up_valid = 1'b1;
        up_data  = 6'h3F;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        @(negedge clk);
        check_all("t5 after", 1, 1, 6'h3F, 1, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
